data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the CPU data port and data memory.
//  - CPU side: the responder end of the CPU byte-wide READ/WRITE/ADDRESS/BUSYWAIT protocol.
//  - Memory side: the initiator of a 32-bit block protocol toward data memory.
//  - Hits complete without stalling the CPU. A miss stalls the CPU via BUSYWAIT for the whole write-back/fetch sequence.
// PARAMETERS
//  INDEX_BITS  3  index width; 2**INDEX_BITS blocks (8)
//  TAG_BITS    3  tag width; TAG_BITS+INDEX_BITS+2 must equal 8 (CPU address width)
// PORTS
//  CLK            in   1   clock; all state updates on posedge
//  RESET          in   1   asynchronous, active-low reset
//  READ           in   1   CPU read request, held until BUSYWAIT low
//  WRITE          in   1   CPU write request, held until BUSYWAIT low
//  ADDRESS        in   8   CPU byte address {tag[7:5], index[4:2], offset[1:0]}
//  WRITEDATA      in   8   CPU write byte
//  READDATA       out  8   CPU read byte
//  BUSYWAIT       out  1   CPU stall
//  MEM_READ       out  1   block fetch strobe
//  MEM_WRITE      out  1   block write-back strobe
//  MEM_ADDRESS    out  6   block address {tag,index}
//  MEM_WRITEDATA  out  32  victim block, byte0 in [7:0]
//  MEM_READDATA   in   32  fetched block, byte0 in [7:0]
//  MEM_BUSYWAIT   in   1   memory busy
// BEHAVIOUR
//  Reset (RESET=0, async)
//  - All valid and dirty bits cleared; FSM to IDLE.
//  - MEM_READ=MEM_WRITE=0, BUSYWAIT=0, READDATA=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
//  - Reset mid-miss aborts the sequence: strobes drop immediately, and the partial block is discarded (stays invalid).
//  Hit = valid[index] && tag[index]==ADDRESS[7:5]. Evaluated combinationally in IDLE.
//  Read hit
//  - READDATA = selected byte of the indexed block, same cycle; BUSYWAIT=0.
//  - READDATA=0 whenever READ=0.
//  Write hit
//  - BUSYWAIT=0; byte written and dirty[index] set at the next posedge.
//  READ and WRITE both high: treated as WRITE.
//  Miss (READ|WRITE and !hit in IDLE)
//  - BUSYWAIT=1 combinationally in the same cycle.
//  - Held high through WRITEBACK, ALLOCATE and UPDATE, and released in IDLE once the access hits.
//  FSM states: IDLE, WRITEBACK, ALLOCATE, UPDATE
//  - IDLE -> WRITEBACK on miss with dirty victim; IDLE -> ALLOCATE on miss with clean or invalid victim.
//  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={old tag,index}, MEM_WRITEDATA=victim block.
//    -> ALLOCATE at the first posedge with MEM_BUSYWAIT=0, after the strobe has been high for at least one full cycle.
//  - ALLOCATE: MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5],index}. Same exit rule -> UPDATE.
//    Data is sampled from MEM_READDATA at that edge.
//  - UPDATE (1 cycle): the array takes the fetched block, the new tag, valid=1, dirty=0 -> IDLE.
//    In IDLE the held request now hits; a held write then sets dirty.
//  - Strobes are registered and stable for the whole state, and are 0 in IDLE and UPDATE.
//  Latency
//  - Hit: 0 stall cycles.
//  - Clean miss: memory latency + 2 cycles.
//  - Dirty miss: 2x memory latency + 2 cycles.
//  CPU address/data are required stable while BUSYWAIT=1; a changed request during a miss is not supported.
// STRUCTURE
//  - cache_defs.vh: FSM state localparams (IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2, UPDATE=2'd3), address field widths, block width.
//  - Sub-module dcache_array: tag/valid/dirty/data storage with async clear, one block-write port and one byte-write port.
//  - data_cache holds the FSM and the hit/byte-select logic.
// TESTING  (memory model: MEM_BUSYWAIT high 5 cycles after a strobe)
//  1. Reset, READ 0x00 -> MEM_READ with MEM_ADDRESS=0x00, no MEM_WRITE. Memory returns 32'hDDCCBBAA -> READDATA=0xAA after UPDATE.
//     Then READ 0x01 -> 0xBB with BUSYWAIT never high.
//  2. WRITE 0x02 data 0x55 (hit) -> no memory strobe, BUSYWAIT=0. Then READ 0x02 -> 0x55.
//  3. READ 0x22 (index 0, tag 1, dirty victim) -> MEM_WRITE, MEM_ADDRESS=0x00, MEM_WRITEDATA=32'hDD55BBAA.
//     Then MEM_READ, MEM_ADDRESS=0x08. Then READDATA = byte2 of the fetched block.
//  4. WRITE 0x45 (clean miss, index 1) -> MEM_READ only, MEM_ADDRESS=0x11.
//     Then the byte is written and dirty set; later eviction of index 1 produces MEM_WRITE.
//  5. RESET=0 mid-ALLOCATE -> MEM_READ and BUSYWAIT drop without a clock edge.
//     Then READ 0x00 misses again (valid cleared).

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared field widths, FSM encoding and byte-select helper for the data cache.
// Address layout is {tag, index, offset}; one block is four bytes, byte0 in the low lane.
package data_cache_pkg;
   localparam int TAG_BITS    = 3;
   localparam int INDEX_BITS  = 3;
   localparam int OFFSET_BITS = 2;
   localparam int ADDR_W      = TAG_BITS + INDEX_BITS + OFFSET_BITS;
   localparam int MEM_ADDR_W  = TAG_BITS + INDEX_BITS;
   localparam int BLOCK_W     = 32;
   localparam int NUM_BLOCKS  = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                           input logic [OFFSET_BITS-1:0] off);
      return blk[{off, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage: combinational read of one set, block fill or byte write per cycle.
// A block fill always leaves the line clean; a byte write always marks it dirty.
module data_cache_array
   import data_cache_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [INDEX_BITS-1:0]  i_index,
   output logic [TAG_BITS-1:0]    o_tag,
   output logic                   o_valid,
   output logic                   o_dirty,
   output logic [BLOCK_W-1:0]     o_block,
   input  logic                   i_blk_we,
   input  logic [TAG_BITS-1:0]    i_blk_tag,
   input  logic [BLOCK_W-1:0]     i_blk_dat,
   input  logic                   i_byte_we,
   input  logic [OFFSET_BITS-1:0] i_byte_off,
   input  logic [7:0]             i_byte_dat
);
   logic [TAG_BITS-1:0]   r_tag  [NUM_BLOCKS];
   logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0] r_valid;
   logic [NUM_BLOCKS-1:0] r_dirty;

   assign o_tag   = r_tag[i_index];
   assign o_valid = r_valid[i_index];
   assign o_dirty = r_dirty[i_index];
   assign o_block = r_data[i_index];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_blk_we) begin
         r_data[i_index]  <= i_blk_dat;
         r_tag[i_index]   <= i_blk_tag;
         r_valid[i_index] <= 1'b1;
         r_dirty[i_index] <= 1'b0;
      end else if (i_byte_we) begin
         r_data[i_index][{i_byte_off, 3'b000} +: 8] <= i_byte_dat;
         r_dirty[i_index] <= 1'b1;
      end
   end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate cache: hits finish with zero stall,
// misses hold BUSYWAIT through optional write-back, block fetch and one update cycle.
module data_cache
   import data_cache_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_read,
   input  logic                  i_write,
   input  logic [ADDR_W-1:0]     i_address,
   input  logic [7:0]            i_writedata,
   output logic [7:0]            o_readdata,
   output logic                  o_busywait,
   output logic                  o_mem_read,
   output logic                  o_mem_write,
   output logic [MEM_ADDR_W-1:0] o_mem_address,
   output logic [BLOCK_W-1:0]    o_mem_writedata,
   input  logic [BLOCK_W-1:0]    i_mem_readdata,
   input  logic                  i_mem_busywait
);
   state_t                  r_state, w_next;
   logic                    r_mem_read, r_mem_write;
   logic [MEM_ADDR_W-1:0]   r_mem_addr;
   logic [BLOCK_W-1:0]      r_mem_wdata, r_fetch;

   logic [TAG_BITS-1:0]     w_tag, w_arr_tag;
   logic [INDEX_BITS-1:0]   w_index;
   logic [OFFSET_BITS-1:0]  w_off;
   logic [BLOCK_W-1:0]      w_block;
   logic                    w_valid, w_dirty, w_hit, w_req, w_idle;

   assign w_tag   = i_address[ADDR_W-1 -: TAG_BITS];
   assign w_index = i_address[OFFSET_BITS +: INDEX_BITS];
   assign w_off   = i_address[OFFSET_BITS-1:0];
   assign w_req   = i_read | i_write;
   assign w_idle  = (r_state == IDLE);
   assign w_hit   = w_valid && (w_arr_tag == w_tag);

   data_cache_array u_array (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_index    (w_index),
      .o_tag      (w_arr_tag),
      .o_valid    (w_valid),
      .o_dirty    (w_dirty),
      .o_block    (w_block),
      .i_blk_we   (r_state == UPDATE),
      .i_blk_tag  (w_tag),
      .i_blk_dat  (r_fetch),
      .i_byte_we  (w_idle && i_write && w_hit),
      .i_byte_off (w_off),
      .i_byte_dat (i_writedata)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_req && !w_hit) w_next = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (!i_mem_busywait) w_next = ALLOCATE;
         ALLOCATE:  if (!i_mem_busywait) w_next = UPDATE;
         UPDATE:    w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // Strobes and memory address are registered from the next state so they are stable for the whole state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_fetch     <= '0;
      end else begin
         r_state     <= w_next;
         r_mem_write <= (w_next == WRITEBACK);
         r_mem_read  <= (w_next == ALLOCATE);
         if (w_idle && w_next == WRITEBACK) begin
            r_mem_addr  <= {w_arr_tag, w_index};
            r_mem_wdata <= w_block;
         end else if (w_next == ALLOCATE && r_state != ALLOCATE) begin
            r_mem_addr <= {w_tag, w_index};
         end
         if (r_state == ALLOCATE && !i_mem_busywait) r_fetch <= i_mem_readdata;
      end
   end

   // Reset gates the miss term so a request held across reset cannot raise the stall.
   assign o_busywait      = i_rst_n && (!w_idle || (w_req && !w_hit));
   assign o_readdata      = (w_idle && i_read && !i_write && w_hit) ? get_byte(w_block, w_off) : 8'h00;
   assign o_mem_read      = r_mem_read;
   assign o_mem_write     = r_mem_write;
   assign o_mem_address   = r_mem_addr;
   assign o_mem_writedata = r_mem_wdata;
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed vector table, reset/read-gating sequences, then random
// accesses compared against a set-level cache model and a 5-cycle-busy memory.
module tb_data_cache;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_read, cpu_write;
   logic [7:0]  cpu_address, cpu_writedata;
   logic [7:0]  o_readdata;
   logic        o_busywait, o_mem_read, o_mem_write;
   logic [5:0]  o_mem_address;
   logic [31:0] o_mem_writedata;
   logic [31:0] mem_rdata = '0;
   logic        mem_busywait = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   data_cache u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_read(cpu_read), .i_write(cpu_write),
      .i_address(cpu_address), .i_writedata(cpu_writedata), .o_readdata(o_readdata),
      .o_busywait(o_busywait), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
      .o_mem_address(o_mem_address), .o_mem_writedata(o_mem_writedata),
      .i_mem_readdata(mem_rdata), .i_mem_busywait(mem_busywait)
   );

   function automatic logic [31:0] init_word(input int i);
      case (i)
         0:       return 32'hDDCCBBAA;
         8:       return 32'h44332211;
         17:      return 32'h88776655;
         25:      return 32'hCAFEF00D;
         default: return 32'(i) * 32'h9E3779B1 + 32'h01234567;
      endcase
   endfunction

   // Memory: raises busy on the negedge after seeing a strobe, completes 5 negedges later.
   typedef struct { int op; logic [5:0] addr; logic [31:0] dat; } memop_t;
   memop_t      mlog[$];
   logic [31:0] dut_mem [64];
   int          m_cnt = 0, m_op = 0, m_done = 0, m_cur = 0;
   bit          m_inited = 0;
   logic [5:0]  m_addr;
   logic [31:0] m_wd;

   always @(negedge clk) begin
      if (!m_inited) begin
         for (int i = 0; i < 64; i++) dut_mem[i] = init_word(i);
         m_inited = 1;
      end
      if (!rst_n) begin
         m_cnt = 0; m_op = 0; m_done = 0; mem_busywait = 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            mem_busywait = 1'b0;
            if (m_op == 1) mem_rdata = dut_mem[m_addr];
            else dut_mem[m_addr] = m_wd;
            m_done = m_op;
         end
      end else begin
         m_cur = o_mem_write ? 2 : (o_mem_read ? 1 : 0);
         if (m_cur == 0) m_done = 0;
         else if (m_cur != m_done) begin
            m_op = m_cur; m_addr = o_mem_address; m_wd = o_mem_writedata;
            m_cnt = 5; mem_busywait = 1'b1;
            mlog.push_back('{m_cur, o_mem_address, o_mem_writedata});
         end
      end
   end

   // Reference cache: per-set arrays and a private copy of memory.
   bit          rm_valid [8];
   bit          rm_dirty [8];
   int          rm_tag   [8];
   logic [31:0] rm_blk   [8];
   logic [31:0] ref_mem  [64];

   task automatic ref_reset();
      for (int i = 0; i < 8; i++) begin rm_valid[i] = 0; rm_dirty[i] = 0; end
   endtask

   task automatic ref_access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                             output logic [7:0] e_rd, output bit e_stall, output bit e_wb,
                             output logic [5:0] e_wba, output logic [31:0] e_wbd,
                             output bit e_fetch, output logic [5:0] e_fa);
      int idx = int'(a[4:2]);
      int tg  = int'(a[7:5]);
      int off = int'(a[1:0]);
      e_rd = 0; e_wb = 0; e_wba = 0; e_wbd = 0; e_fetch = 0; e_fa = 0;
      e_stall = !(rm_valid[idx] && rm_tag[idx] == tg);
      if (e_stall) begin
         if (rm_valid[idx] && rm_dirty[idx]) begin
            e_wb = 1; e_wba = 6'(rm_tag[idx] * 8 + idx); e_wbd = rm_blk[idx];
            ref_mem[e_wba] = rm_blk[idx];
         end
         e_fetch = 1; e_fa = 6'(tg * 8 + idx);
         rm_blk[idx] = ref_mem[e_fa]; rm_valid[idx] = 1; rm_tag[idx] = tg; rm_dirty[idx] = 0;
      end
      if (wr) begin
         rm_blk[idx][off*8 +: 8] = wd; rm_dirty[idx] = 1;
      end else if (rd) begin
         e_rd = rm_blk[idx][off*8 +: 8];
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic dut_access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                             output logic [7:0] rdata, output bit stalled, output bit timeout);
      int cyc = 0;
      @(posedge clk); #1;
      cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_writedata = wd;
      #1;
      stalled = 0;
      while (o_busywait && cyc < 200) begin
         stalled = 1;
         @(posedge clk); #2;
         cyc++;
      end
      timeout = o_busywait;
      rdata = o_readdata;
      @(posedge clk); #1;
      cpu_read = 0; cpu_write = 0;
   endtask

   task automatic check_access(input string nm, input logic rd, input logic wr, input int base,
                               input logic [7:0] a_rd, input bit a_stall, input bit a_to,
                               input logic [7:0] e_rd, input bit e_stall, input bit e_wb,
                               input logic [5:0] e_wba, input logic [31:0] e_wbd,
                               input bit e_fetch, input logic [5:0] e_fa);
      int n = mlog.size() - base;
      chk({nm, "_timeout"}, 32'(a_to), 0);
      chk({nm, "_stall"}, 32'(a_stall), 32'(e_stall));
      if (rd && !wr) chk({nm, "_rdata"}, 32'(a_rd), 32'(e_rd));
      chk({nm, "_nops"}, 32'(n), 32'(int'(e_wb) + int'(e_fetch)));
      if (e_wb && n >= 1) begin
         chk({nm, "_wb_op"}, 32'(mlog[base].op), 2);
         chk({nm, "_wb_addr"}, 32'(mlog[base].addr), 32'(e_wba));
         chk({nm, "_wb_data"}, mlog[base].dat, e_wbd);
      end
      if (e_fetch && n >= 1) begin
         chk({nm, "_rd_op"}, 32'(mlog[base + n - 1].op), 1);
         chk({nm, "_rd_addr"}, 32'(mlog[base + n - 1].addr), 32'(e_fa));
      end
   endtask

   typedef struct {
      logic rd; logic wr; logic [7:0] addr; logic [7:0] wd; logic [7:0] e_rd; bit e_stall;
      bit e_wb; logic [5:0] e_wba; logic [31:0] e_wbd; bit e_fetch; logic [5:0] e_fa;
   } vec_t;

   initial begin
      vec_t        vecs[10];
      logic [7:0]  a_rd, e_rd, a, wd;
      bit          a_stall, a_to, e_stall, e_wb, e_fetch;
      logic [5:0]  e_wba, e_fa;
      logic [31:0] e_wbd;
      logic        rd, wr;
      int          base, op;

      vecs[0] = '{1, 0, 8'h00, 8'h00, 8'hAA, 1, 0, 6'h00, 32'h0,         1, 6'h00};
      vecs[1] = '{1, 0, 8'h01, 8'h00, 8'hBB, 0, 0, 6'h00, 32'h0,         0, 6'h00};
      vecs[2] = '{0, 1, 8'h02, 8'h55, 8'h00, 0, 0, 6'h00, 32'h0,         0, 6'h00};
      vecs[3] = '{1, 0, 8'h02, 8'h00, 8'h55, 0, 0, 6'h00, 32'h0,         0, 6'h00};
      vecs[4] = '{1, 0, 8'h22, 8'h00, 8'h33, 1, 1, 6'h00, 32'hDD55BBAA, 1, 6'h08};
      vecs[5] = '{0, 1, 8'h45, 8'h9C, 8'h00, 1, 0, 6'h00, 32'h0,         1, 6'h11};
      vecs[6] = '{1, 0, 8'h45, 8'h00, 8'h9C, 0, 0, 6'h00, 32'h0,         0, 6'h00};
      vecs[7] = '{1, 0, 8'h65, 8'h00, 8'hF0, 1, 1, 6'h11, 32'h88779C55, 1, 6'h19};
      vecs[8] = '{1, 1, 8'h66, 8'h77, 8'h00, 0, 0, 6'h00, 32'h0,         0, 6'h00};
      vecs[9] = '{1, 0, 8'h66, 8'h00, 8'h77, 0, 0, 6'h00, 32'h0,         0, 6'h00};

      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      ref_reset();
      rst_n = 0; cpu_read = 0; cpu_write = 0; cpu_address = 0; cpu_writedata = 0;

      repeat (2) @(posedge clk);
      #2;
      chk("rst_busywait", 32'(o_busywait), 0);
      chk("rst_readdata", 32'(o_readdata), 0);
      chk("rst_mem_read", 32'(o_mem_read), 0);
      chk("rst_mem_write", 32'(o_mem_write), 0);
      chk("rst_mem_address", 32'(o_mem_address), 0);
      chk("rst_mem_writedata", o_mem_writedata, 0);
      #1 rst_n = 1;

      for (int i = 0; i < 10; i++) begin
         base = mlog.size();
         dut_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, a_rd, a_stall, a_to);
         ref_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, e_rd, e_stall, e_wb, e_wba, e_wbd, e_fetch, e_fa);
         check_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, base, a_rd, a_stall, a_to,
                      vecs[i].e_rd, vecs[i].e_stall, vecs[i].e_wb, vecs[i].e_wba, vecs[i].e_wbd,
                      vecs[i].e_fetch, vecs[i].e_fa);
      end

      // READDATA follows READ on a hitting address within the cycle.
      @(posedge clk); #1;
      cpu_address = 8'h22; cpu_read = 0;
      #1 chk("rd_low_readdata", 32'(o_readdata), 0);
      cpu_read = 1;
      #1 chk("rd_high_readdata", 32'(o_readdata), 32'h33);
      chk("rd_high_busywait", 32'(o_busywait), 0);
      cpu_read = 0;

      // Reset in the middle of a block fetch.
      @(posedge clk); #1;
      cpu_address = 8'h80; cpu_read = 1;
      repeat (2) @(posedge clk);
      #3;
      chk("alloc_mem_read", 32'(o_mem_read), 1);
      chk("alloc_mem_address", 32'(o_mem_address), 32'h20);
      chk("alloc_busywait", 32'(o_busywait), 1);
      rst_n = 0;
      #1;
      chk("abort_mem_read", 32'(o_mem_read), 0);
      chk("abort_mem_write", 32'(o_mem_write), 0);
      chk("abort_busywait", 32'(o_busywait), 0);
      chk("abort_mem_address", 32'(o_mem_address), 0);
      ref_reset();
      cpu_read = 0;
      @(negedge clk); #2 rst_n = 1;
      base = mlog.size();
      dut_access(1, 0, 8'h00, 8'h00, a_rd, a_stall, a_to);
      ref_access(1, 0, 8'h00, 8'h00, e_rd, e_stall, e_wb, e_wba, e_wbd, e_fetch, e_fa);
      check_access("post_reset", 1, 0, base, a_rd, a_stall, a_to, e_rd, e_stall, e_wb, e_wba, e_wbd, e_fetch, e_fa);

      for (int i = 0; i < 300; i++) begin
         op = int'($urandom_range(0, 3));
         rd = (op != 2);
         wr = (op >= 2);
         a  = {3'($urandom_range(0, 2)), 5'($urandom_range(0, 31))};
         wd = 8'($urandom);
         base = mlog.size();
         dut_access(rd, wr, a, wd, a_rd, a_stall, a_to);
         ref_access(rd, wr, a, wd, e_rd, e_stall, e_wb, e_wba, e_wbd, e_fetch, e_fa);
         check_access($sformatf("rand%0d", i), rd, wr, base, a_rd, a_stall, a_to,
                      e_rd, e_stall, e_wb, e_wba, e_wbd, e_fetch, e_fa);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
